// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection controller.
// Lamp decode helpers keep the NS/EW mapping in one place.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    function automatic logic [2:0] ns_lamp(input state_t s);
        case (s)
            NS_GREEN:  return LIGHT_GREEN;
            NS_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_t s);
        case (s)
            EW_GREEN:  return LIGHT_GREEN;
            EW_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Shared phase dwell timer: counts cycles spent in the current phase.
// term flags cnt >= limit-1; with sat set the count parks at that value.
module traffic_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             sat,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    assign term = (cnt >= (limit - CNT_W'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!(sat && term)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection sequencer with pedestrian walk insertion.
// Lamp outputs are registered from next_state so they switch with the state register.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned GREEN_CYCLES  = 8,
    parameter int unsigned YELLOW_CYCLES = 2,
    parameter int unsigned ALLRED_CYCLES = 1,
    parameter int unsigned WALK_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] ns_lights,
    output logic [2:0] ew_lights,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if (GREEN_CYCLES  < 1 || GREEN_CYCLES  > CNT_MAX ||
        YELLOW_CYCLES < 1 || YELLOW_CYCLES > CNT_MAX ||
        ALLRED_CYCLES < 1 || ALLRED_CYCLES > CNT_MAX ||
        WALK_CYCLES   < 1 || WALK_CYCLES   > CNT_MAX) begin : g_bad_dwell
        $error("traffic_intersection_ctrl: dwell parameter outside 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(GREEN_CYCLES);
    localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] ALLRED_L = CNT_W'(ALLRED_CYCLES);
    localparam logic [CNT_W-1:0] WALK_L   = CNT_W'(WALK_CYCLES);

    state_t           state, next_state;
    dir_t             next_dir, next_dir_nxt;
    logic             ped_pending, ped_pending_nxt;
    logic             enter_walk;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] cnt_unused;
    logic             term;

    traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (next_state != state),
        .sat     (state == NS_GREEN),
        .limit   (limit),
        .cnt     (cnt_unused),
        .term    (term)
    );

    always_comb begin
        next_state   = state;
        next_dir_nxt = next_dir;
        limit        = ALLRED_L;
        case (state)
            NS_GREEN: begin
                limit = GREEN_L;
                if (term && (ew_car || ped_pending)) next_state = NS_YELLOW;
            end
            NS_YELLOW: begin
                limit = YELLOW_L;
                if (term) next_state = ALLRED_A;
            end
            ALLRED_A: begin
                if (term) begin
                    next_dir_nxt = DIR_EW;
                    next_state   = ped_pending ? PED_WALK : EW_GREEN;
                end
            end
            EW_GREEN: begin
                limit = GREEN_L;
                if (term) next_state = EW_YELLOW;
            end
            EW_YELLOW: begin
                limit = YELLOW_L;
                if (term) next_state = ALLRED_B;
            end
            ALLRED_B: begin
                if (term) begin
                    next_dir_nxt = DIR_NS;
                    next_state   = ped_pending ? PED_WALK : NS_GREEN;
                end
            end
            PED_WALK: begin
                limit = WALK_L;
                if (term) next_state = (next_dir == DIR_EW && ew_car) ? EW_GREEN : NS_GREEN;
            end
            default: next_state = ALLRED_B;
        endcase
    end

    // Entering the walk consumes the request, even one arriving on the same edge.
    always_comb begin
        enter_walk      = (next_state == PED_WALK) && (state != PED_WALK);
        ped_pending_nxt = ped_pending;
        if (enter_walk) begin
            ped_pending_nxt = 1'b0;
        end else if (state != PED_WALK && ped_req) begin
            ped_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ALLRED_B;
            next_dir    <= DIR_NS;
            ped_pending <= 1'b0;
            ns_lights   <= LIGHT_RED;
            ew_lights   <= LIGHT_RED;
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            state       <= next_state;
            next_dir    <= next_dir_nxt;
            ped_pending <= ped_pending_nxt;
            ns_lights   <= ns_lamp(next_state);
            ew_lights   <= ew_lamp(next_state);
            walk        <= (next_state == PED_WALK);
            ped_ack     <= enter_walk;
        end
    end

    assign phase = state;

endmodule
